reg_file_param: RTL and testbench

Parametrised register file: 2**ADDR_W entries of WIDTH bits, one synchronous write port, two asynchronous read ports. Writes are steered by an internal ADDR_W-to-2**ADDR_W one-hot write decoder gated by the write enable. The block adds three features:

- optional write-to-read bypass
- optional hardwired-zero entry 0
- per-entry "written since reset" valid tracking

It is the register-file stage of the CPU datapath and replaces the fixed 8x16 file.

---
 rtl/reg_file_param.sv | 87 ++++++++
 tb/tb_reg_file_param.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_param.sv
// Parametrised register file: 2**ADDR_W x WIDTH entries, one synchronous write
// port, two combinational read ports, optional write-to-read bypass, optional
// hardwired-zero entry 0 and per-entry "written since reset" valid bits.
module reg_file_param #(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned ADDR_W   = 3,
  parameter int unsigned BYPASS   = 1,
  parameter int unsigned ZERO_REG = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic [WIDTH-1:0]  rd_data1,
  output logic [WIDTH-1:0]  rd_data2,
  output logic              rd_valid1,
  output logic              rd_valid2
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [DEPTH-1:0] r_valid;
  logic [DEPTH-1:0] w_wr_dec;
  logic             w_wr_act;

  // A write is live only outside reset; reset wins over a concurrent write.
  assign w_wr_act = wr_en && !rst;

  // One-hot write decoder gated by the write enable; entry 0 masked when hardwired.
  always_comb begin
    w_wr_dec = '0;
    if (w_wr_act) begin
      w_wr_dec[wr_addr] = 1'b1;
    end
    if (ZERO_REG != 0) begin
      w_wr_dec[0] = 1'b0;
    end
  end

  // Array and sticky valid bits; asynchronous clear on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_valid <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (w_wr_dec[i]) begin
          r_mem[i]   <= wr_data;
          r_valid[i] <= 1'b1;
        end
      end
    end
  end

  // Read port 1: zero entry, then bypass, then array.
  always_comb begin
    rd_data1  = r_mem[rd_addr1];
    rd_valid1 = r_valid[rd_addr1];
    if ((ZERO_REG != 0) && (rd_addr1 == '0)) begin
      rd_data1  = '0;
      rd_valid1 = 1'b1;
    end else if ((BYPASS != 0) && w_wr_act && (rd_addr1 == wr_addr)) begin
      rd_data1  = wr_data;
      rd_valid1 = 1'b1;
    end
  end

  // Read port 2: same priority as port 1, resolved independently.
  always_comb begin
    rd_data2  = r_mem[rd_addr2];
    rd_valid2 = r_valid[rd_addr2];
    if ((ZERO_REG != 0) && (rd_addr2 == '0)) begin
      rd_data2  = '0;
      rd_valid2 = 1'b1;
    end else if ((BYPASS != 0) && w_wr_act && (rd_addr2 == wr_addr)) begin
      rd_data2  = wr_data;
      rd_valid2 = 1'b1;
    end
  end

endmodule

// File: tb/tb_reg_file_param.sv
// Directed bench for reg_file_param: three instances sharing one stimulus
// (bypass on, bypass off, hardwired zero entry) checked against hand values.
module tb_reg_file_param;

  logic        clk;
  logic        rst;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [15:0] wr_data;
  logic [2:0]  rd_addr1;
  logic [2:0]  rd_addr2;

  logic [15:0] b_d1, b_d2, n_d1, n_d2, z_d1, z_d2;
  logic        b_v1, b_v2, n_v1, n_v2, z_v1, z_v2;

  int n_vec;
  int n_err;

  reg_file_param #(.WIDTH(16), .ADDR_W(3), .BYPASS(1), .ZERO_REG(0)) u_dut_byp (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .rd_data1(b_d1), .rd_data2(b_d2), .rd_valid1(b_v1), .rd_valid2(b_v2)
  );

  reg_file_param #(.WIDTH(16), .ADDR_W(3), .BYPASS(0), .ZERO_REG(0)) u_dut_nobyp (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .rd_data1(n_d1), .rd_data2(n_d2), .rd_valid1(n_v1), .rd_valid2(n_v2)
  );

  reg_file_param #(.WIDTH(16), .ADDR_W(3), .BYPASS(1), .ZERO_REG(1)) u_dut_zero (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .rd_data1(z_d1), .rd_data2(z_d2), .rd_valid1(z_v1), .rd_valid2(z_v2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drive a write (or idle) for the coming edge.
  task automatic drive_wr(input logic en, input logic [2:0] a, input logic [15:0] d);
    wr_en   = en;
    wr_addr = a;
    wr_data = d;
  endtask

  initial begin
    logic [15:0] exp1;
    logic [15:0] exp2;
    n_vec    = 0;
    n_err    = 0;
    rst      = 1'b1;
    rd_addr1 = '0;
    rd_addr2 = '0;
    drive_wr(1'b0, 3'd0, 16'h0000);

    // Reset held across an edge, released at a falling edge.
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Reset state sweep.
    for (int a = 0; a < 8; a++) begin
      rd_addr1 = 3'(a);
      rd_addr2 = 3'(7 - a);
      #1;
      check("rst_d1", {16'h0, b_d1}, 32'h0);
      check("rst_d2", {16'h0, b_d2}, 32'h0);
      check("rst_v1", {31'h0, b_v1}, 32'h0);
      check("rst_v2", {31'h0, b_v2}, 32'h0);
      check("rst_zv1", {31'h0, z_v1}, (a == 0) ? 32'h1 : 32'h0);
      check("rst_zd1", {16'h0, z_d1}, 32'h0);
    end

    // Same-cycle read of an unwritten entry: bypass gives new data, otherwise old.
    @(negedge clk);
    drive_wr(1'b1, 3'd2, 16'h1234);
    rd_addr1 = 3'd2;
    rd_addr2 = 3'd2;
    #1;
    check("byp0_d", {16'h0, b_d1}, 32'h1234);
    check("byp0_v", {31'h0, b_v2}, 32'h1);
    check("nob0_d", {16'h0, n_d1}, 32'h0);
    check("nob0_v", {31'h0, n_v2}, 32'h0);

    // Write sweep 16'h1111*i to address i.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      drive_wr(1'b1, 3'(i), 16'(16'h1111 * i));
    end
    @(negedge clk);
    drive_wr(1'b0, 3'd0, 16'h0000);
    for (int i = 0; i < 8; i++) begin
      rd_addr1 = 3'(i);
      rd_addr2 = 3'(7 - i);
      exp1 = 16'(16'h1111 * i);
      exp2 = 16'(16'h1111 * (7 - i));
      #1;
      check("swp_b_d1", {16'h0, b_d1}, {16'h0, exp1});
      check("swp_b_d2", {16'h0, b_d2}, {16'h0, exp2});
      check("swp_b_v", {30'h0, b_v1, b_v2}, 32'h3);
      check("swp_n_d1", {16'h0, n_d1}, {16'h0, exp1});
      check("swp_n_d2", {16'h0, n_d2}, {16'h0, exp2});
      check("swp_z_d1", {16'h0, z_d1}, (i == 0) ? 32'h0 : {16'h0, exp1});
    end

    // Write enable low for three edges: entry 5 unchanged.
    drive_wr(1'b0, 3'd5, 16'hFFFF);
    rd_addr1 = 3'd5;
    rd_addr2 = 3'd5;
    repeat (3) @(posedge clk);
    #1;
    check("wen_b_d", {16'h0, b_d1}, 32'h5555);
    check("wen_n_d", {16'h0, n_d2}, 32'h5555);
    check("wen_v", {31'h0, b_v1}, 32'h1);

    // Bypass: address 3 holds 16'hAAAA, then write 16'h5555.
    @(negedge clk);
    drive_wr(1'b1, 3'd3, 16'hAAAA);
    @(negedge clk);
    drive_wr(1'b1, 3'd3, 16'h5555);
    rd_addr1 = 3'd3;
    rd_addr2 = 3'd3;
    #1;
    check("byp_b_d1", {16'h0, b_d1}, 32'h5555);
    check("byp_b_d2", {16'h0, b_d2}, 32'h5555);
    check("byp_n_d1", {16'h0, n_d1}, 32'hAAAA);
    check("byp_n_d2", {16'h0, n_d2}, 32'hAAAA);
    @(posedge clk);
    #1;
    drive_wr(1'b0, 3'd0, 16'h0000);
    #1;
    check("aft_b_d1", {16'h0, b_d1}, 32'h5555);
    check("aft_n_d1", {16'h0, n_d1}, 32'h5555);
    check("aft_n_d2", {16'h0, n_d2}, 32'h5555);

    // Zero register: write 16'hBEEF to address 0.
    @(negedge clk);
    drive_wr(1'b1, 3'd0, 16'hBEEF);
    rd_addr1 = 3'd0;
    rd_addr2 = 3'd0;
    #1;
    check("zr_pre_d", {16'h0, z_d1}, 32'h0);
    check("zr_pre_v", {31'h0, z_v2}, 32'h1);
    @(negedge clk);
    drive_wr(1'b1, 3'd1, 16'hBEEF);
    rd_addr2 = 3'd1;
    #1;
    check("zr_post_d", {16'h0, z_d1}, 32'h0);
    check("zr_post_v", {31'h0, z_v1}, 32'h1);
    check("zr_b_e0", {16'h0, b_d1}, 32'hBEEF);
    @(negedge clk);
    drive_wr(1'b0, 3'd0, 16'h0000);
    #1;
    check("zr_e1", {16'h0, z_d2}, 32'hBEEF);
    check("zr_e0", {16'h0, z_d1}, 32'h0);

    // Back-to-back writes to address 6: each value visible for one cycle.
    drive_wr(1'b1, 3'd6, 16'h0A0A);
    rd_addr1 = 3'd6;
    @(posedge clk);
    #1;
    drive_wr(1'b1, 3'd6, 16'h0B0B);
    #1;
    check("b2b_first", {16'h0, n_d1}, 32'h0A0A);
    @(posedge clk);
    #1;
    drive_wr(1'b0, 3'd0, 16'h0000);
    #1;
    check("b2b_last", {16'h0, n_d1}, 32'h0B0B);

    // Asynchronous reset between edges, with a write held during reset.
    @(negedge clk);
    rst = 1'b1;
    drive_wr(1'b1, 3'd4, 16'h7777);
    rd_addr1 = 3'd4;
    rd_addr2 = 3'd1;
    #1;
    check("ar_b_d1", {16'h0, b_d1}, 32'h0);
    check("ar_b_v1", {31'h0, b_v1}, 32'h0);
    check("ar_n_d2", {16'h0, n_d2}, 32'h0);
    check("ar_n_v2", {31'h0, n_v2}, 32'h0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    drive_wr(1'b0, 3'd0, 16'h0000);
    #1;
    check("ar_lost_d", {16'h0, b_d1}, 32'h0);
    check("ar_lost_v", {31'h0, n_v1}, 32'h0);
    rd_addr1 = 3'd0;
    #1;
    check("ar_z_v", {31'h0, z_v1}, 32'h1);

    // First write after reset release is accepted.
    drive_wr(1'b1, 3'd4, 16'h1357);
    rd_addr1 = 3'd4;
    @(posedge clk);
    #1;
    drive_wr(1'b0, 3'd0, 16'h0000);
    #1;
    check("post_rst_d", {16'h0, n_d1}, 32'h1357);
    check("post_rst_v", {31'h0, n_v1}, 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
